pb_conditioner: RTL and testbench
=================================

Name: pb_conditioner

Overview:
- Conditions the raw push-button bus before it reaches the key, opcode and register decoders.
- Per button: two-flop synchroniser, debounce filter, registered clean level, and a single-cycle press strobe.
- Downstream decoders therefore see exactly one strobe per physical press.
- Sits between the pb pins and the keyencoder_binary / opcode_encoder / register_decoder stage.

Parameters:
- N_BTN, 21, number of button lines conditioned.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a level change is accepted (>=2). Use 16 in sim, 100000 on hardware.
- REPEAT_DELAY, 64, cycles a lone held button waits before the first auto-repeat strobe (REPEAT_EN only).
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeat strobes (REPEAT_EN only).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- pb_raw  input  N_BTN  asynchronous button pins, 1 = pressed.
- pb_level  output  N_BTN  debounced level, registered.
- pb_strobe  output  N_BTN  one-cycle pulse on accepted 0->1 transition, registered.
- any_strobe  output  1  OR of pb_strobe, same cycle as pb_strobe.

Behaviour:
- Reset: clk and reset are one clock; reset is synchronous and active-high. While reset is sampled high, the following are all 0: both sync stages, pb_level, pb_strobe, any_strobe, all counters, repeat state.
- Sync: s1 <= pb_raw; s2 <= s1. The filter observes s2 only.
- Per-button counter cnt:
  - If s2 == pb_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: pb_level flips and cnt <= 0.
  - Else: cnt++.
- Latency: a clean change first sampled into s1 at edge E appears on pb_level after edge E+DEBOUNCE_CYCLES+1.
- Bounce: any s2 sample that matches pb_level before cnt reaches DEBOUNCE_CYCLES-1 restarts the count. No output change.
- Strobe: pb_strobe[i] is 1 for exactly the cycle following the edge where pb_level[i] goes 0->1. It is 0 otherwise, and 0 on release.
- Buttons are independent. Simultaneous presses yield simultaneous strobe bits. No priority is applied; the decoders arbitrate.
- A button held through reset release is treated as a new press: strobe fires DEBOUNCE_CYCLES+1 cycles after the first post-reset sampling edge.
- Reset asserted mid-count discards the partial count.
- cnt width = $clog2(DEBOUNCE_CYCLES). It never wraps, because the terminal compare precedes the increment.

Optional Feature:
- Macro: PB_AUTOREPEAT_EN.
- Defined:
  - A single shared repeat FSM with states IDLE, DELAY, REPEAT and a counter rcnt.
  - IDLE -> DELAY when pb_level is one-hot and that bit just strobed; rcnt <= 0.
  - DELAY -> REPEAT when rcnt == REPEAT_DELAY-1: one extra strobe on that bit, rcnt <= 0.
  - In REPEAT, one strobe every REPEAT_PERIOD cycles.
  - Any change of pb_level (release, or a second button) -> IDLE with no strobe.
  - Multi-button holds never repeat.
- Undefined: no repeat logic is synthesised; strobes occur only on press.

Decomposition:
- Package pb_pkg holds:
  - localparam N_BTN_DEF = 21.
  - DEBOUNCE_SIM = 16, DEBOUNCE_HW = 100000.
  - typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t.
- Sub-module pb_debounce_cell: one button (sync, cnt, level, strobe), instantiated N_BTN times via generate.
- The top-level of this block adds any_strobe and the optional repeat FSM.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
- Clean press: pb_raw[5] 0->1 sampled at edge 0, held -> pb_level[5]=1 after edge 5; pb_strobe[5] and any_strobe high only cycle 5->6.
- Bounce: pb_raw[3] toggles 1,0,1,0 on alternate cycles, then stays 0 -> pb_level[3] stays 0 and no strobe. Then 1 held for 6 cycles -> exactly one strobe.
- Release: from pb_level[10]=1, raw to 0 -> pb_level[10]=0 five edges later; pb_strobe[10] never asserts.
- Simultaneous: pb_raw[0] and pb_raw[17] rise on the same edge -> both strobe bits set in the same cycle, any_strobe=1 for one cycle.
- Reset: press held, reset asserted at count 2 for one cycle, then released -> all outputs 0 during reset; strobe fires 5 edges after the first post-reset sampling edge.
- PB_AUTOREPEAT_EN: hold only pb_raw[7] -> first strobe, then a repeat strobe 8 cycles later, then every 3 cycles. Pressing pb_raw[8] stops repeats for bit 7, and pb[8]'s own press strobe still fires.

Source files
------------

// File: rtl/pb_pkg.sv
// pb_pkg: shared constants and types for the push-button conditioner
package pb_pkg;
  localparam int N_BTN_DEF = 21;
  localparam int DEBOUNCE_SIM = 16;
  localparam int DEBOUNCE_HW = 100000;
  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;
endpackage

// File: rtl/pb_debounce_cell.sv
// pb_debounce_cell: synchronise, debounce and strobe one button (PB_AUTOREPEAT_EN adds level_nxt)
module pb_debounce_cell import pb_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic strobe
`ifdef PB_AUTOREPEAT_EN
  ,
  output logic level_nxt
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic s1, s2, done, nxt;
  logic [CW-1:0] cnt;
  assign done = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign nxt = done ? ~level : level;
`ifdef PB_AUTOREPEAT_EN
  assign level_nxt = nxt;
`endif
  // two-flop sync, stability counter, accepted level and rising-edge strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
      strobe <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 == level || done) ? '0 : cnt + 1'b1;
      level <= nxt;
      strobe <= nxt & ~level;
    end
  end
endmodule

// File: rtl/pb_conditioner.sv
// pb_conditioner: per-button debounce/strobe bus; PB_AUTOREPEAT_EN adds a shared auto-repeat FSM
module pb_conditioner import pb_pkg::*; #(
  parameter int N_BTN = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
`ifdef PB_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_PERIOD = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] pb_raw,
  output logic [N_BTN-1:0] pb_level,
  output logic [N_BTN-1:0] pb_strobe,
  output logic             any_strobe
);
  logic [N_BTN-1:0] cell_strobe;
`ifdef PB_AUTOREPEAT_EN
  logic [N_BTN-1:0] level_nxt;
`endif
  genvar i;
  generate
    for (i = 0; i < N_BTN; i++) begin : g_btn
      pb_debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
        .clk(clk),
        .reset(reset),
        .raw(pb_raw[i]),
        .level(pb_level[i]),
        .strobe(cell_strobe[i])
`ifdef PB_AUTOREPEAT_EN
        ,
        .level_nxt(level_nxt[i])
`endif
      );
    end
  endgenerate
`ifdef PB_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  rpt_state_t state;
  logic [RW-1:0] rcnt, rlim;
  logic [N_BTN-1:0] rpt_strobe;
  logic chg, fresh;
  assign chg = level_nxt != pb_level;
  assign fresh = $onehot(level_nxt) && ((level_nxt & ~pb_level) == level_nxt);
  assign rlim = (state == RPT_DELAY) ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
  // arm on a lone fresh press, repeat while the level bus stays unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RPT_IDLE;
      rcnt <= '0;
      rpt_strobe <= '0;
    end else begin
      rpt_strobe <= '0;
      if (state == RPT_IDLE) begin
        state <= fresh ? RPT_DELAY : RPT_IDLE;
        rcnt <= '0;
      end else if (chg) begin
        state <= RPT_IDLE;
        rcnt <= '0;
      end else if (rcnt == rlim) begin
        state <= RPT_REPEAT;
        rcnt <= '0;
        rpt_strobe <= pb_level;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end
  assign pb_strobe = cell_strobe | rpt_strobe;
`else
  assign pb_strobe = cell_strobe;
`endif
  assign any_strobe = |pb_strobe;
endmodule

// File: tb/tb_pb_conditioner.sv
// tb_pb_conditioner: directed checks of debounce, strobe, reset and optional auto-repeat
module tb_pb_conditioner;
  localparam int N = 21;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] pb_raw = '0;
  logic [N-1:0] pb_level, pb_strobe;
  logic any_strobe;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pb_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(4)
`ifdef PB_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(3)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .pb_raw(pb_raw),
    .pb_level(pb_level),
    .pb_strobe(pb_strobe),
    .any_strobe(any_strobe)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_all(input string tag);
    pb_raw = '0;
    repeat (10) tick();
    n_cmp++;
    if (pb_level !== '0 || pb_strobe !== '0) begin
      n_bad++;
      $display("FAIL %s_idle level=%h strobe=%h want 0", tag, pb_level, pb_strobe);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pb_raw = '1;
    repeat (4) tick();
    n_cmp++;
    if (pb_level !== '0) begin n_bad++; $display("FAIL reset_level got %h want 0", pb_level); end
    n_cmp++;
    if (pb_strobe !== '0) begin n_bad++; $display("FAIL reset_strobe got %h want 0", pb_strobe); end
    n_cmp++;
    if (any_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_any got %b want 0", any_strobe); end
    pb_raw = '0;
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (pb_level !== '0 || pb_strobe !== '0) begin
      n_bad++;
      $display("FAIL reset_after level=%h strobe=%h want 0", pb_level, pb_strobe);
    end
  endtask

  task automatic test_clean_press;
    logic [N-1:0] m;
    m = '0;
    m[5] = 1'b1;
    pb_raw = m;
    for (int t = 0; t <= 6; t++) begin
      tick();
      n_cmp++;
      if (pb_level !== (t >= 5 ? m : '0) || pb_strobe !== (t == 5 ? m : '0) || any_strobe !== (t == 5)) begin
        n_bad++;
        $display("FAIL press t=%0d level=%h strobe=%h any=%b want level=%h strobe=%h any=%b",
                 t, pb_level, pb_strobe, any_strobe, t >= 5 ? m : '0, t == 5 ? m : '0, t == 5);
      end
    end
    release_all("press");
  endtask

  task automatic test_bounce;
    int seen;
    logic [7:0] pat;
    pat = 8'b0011_0011;
    for (int t = 0; t < 14; t++) begin
      pb_raw[3] = t < 8 ? pat[t] : 1'b0;
      tick();
      n_cmp++;
      if (pb_level[3] !== 1'b0 || pb_strobe[3] !== 1'b0) begin
        n_bad++;
        $display("FAIL bounce t=%0d level=%b strobe=%b want 0 0", t, pb_level[3], pb_strobe[3]);
      end
    end
    seen = 0;
    for (int t = 0; t < 14; t++) begin
      pb_raw[3] = t < 6;
      tick();
      if (pb_strobe[3] === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 1) begin n_bad++; $display("FAIL bounce_hold strobes=%0d want 1", seen); end
    release_all("bounce");
  endtask

  task automatic test_release;
    pb_raw[10] = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (pb_level[10] !== 1'b1) begin n_bad++; $display("FAIL release_up level=%b want 1", pb_level[10]); end
    pb_raw[10] = 1'b0;
    for (int t = 0; t <= 6; t++) begin
      tick();
      n_cmp++;
      if (pb_level[10] !== (t < 5) || pb_strobe[10] !== 1'b0) begin
        n_bad++;
        $display("FAIL release t=%0d level=%b strobe=%b want %b 0", t, pb_level[10], pb_strobe[10], t < 5);
      end
    end
    release_all("release");
  endtask

  task automatic test_simultaneous;
    logic [N-1:0] m;
    m = '0;
    m[0] = 1'b1;
    m[17] = 1'b1;
    pb_raw = m;
    for (int t = 0; t <= 6; t++) begin
      tick();
      n_cmp++;
      if (pb_strobe !== (t == 5 ? m : '0) || any_strobe !== (t == 5)) begin
        n_bad++;
        $display("FAIL simul t=%0d strobe=%h any=%b want %h %b", t, pb_strobe, any_strobe, t == 5 ? m : '0, t == 5);
      end
    end
    release_all("simul");
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] m;
    m = '0;
    m[5] = 1'b1;
    pb_raw = m;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (pb_level !== '0 || pb_strobe !== '0 || any_strobe !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_outs level=%h strobe=%h any=%b want 0", pb_level, pb_strobe, any_strobe);
    end
    reset = 1'b0;
    for (int t = 0; t <= 6; t++) begin
      tick();
      n_cmp++;
      if (pb_level !== (t >= 5 ? m : '0) || pb_strobe !== (t == 5 ? m : '0)) begin
        n_bad++;
        $display("FAIL midreset t=%0d level=%h strobe=%h want %h %h", t, pb_level, pb_strobe, t >= 5 ? m : '0, t == 5 ? m : '0);
      end
    end
    release_all("midreset");
  endtask

`ifdef PB_AUTOREPEAT_EN
  task automatic test_autorepeat;
    logic [N-1:0] exp;
    pb_raw[7] = 1'b1;
    for (int t = 0; t <= 40; t++) begin
      tick();
      exp = '0;
      exp[7] = (t == 5 || t == 13 || t == 16 || t == 19 || t == 22 || t == 25);
      exp[8] = (t == 28);
      n_cmp++;
      if (pb_strobe !== exp) begin
        n_bad++;
        $display("FAIL repeat t=%0d strobe=%h want %h", t, pb_strobe, exp);
      end
      if (t == 22) pb_raw[8] = 1'b1;
    end
    release_all("repeat");
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
`ifdef PB_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
